// File: rtl/machine_timer_if.sv
// rtl/machine_timer_if.sv - simple data bus between core and machine timer
// Single-cycle request/ack bus; the master issues at most one access per cycle.
interface machine_timer_if;
   logic        bus_req;
   logic        bus_we;
   logic [4:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/machine_timer.sv
// rtl/machine_timer.sv - mtime/mtimecmp/msip block driving timer and software pending bits
// The 64-bit mtime advances once every TICK_DIV cycles and freezes while the hart is halted.
module machine_timer #(
   parameter int TICK_DIV = 1
) (
   input  logic            clk,
   input  logic            rst,
   machine_timer_if.slave  bus,
   input  logic            dbg_halt,
   output logic            xTIP,
   output logic            xSIP
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [63:0]   mtime;
   logic [63:0]   mtimecmp;
   logic          msip;
   logic [31:0]   hi_shadow;
   logic [PW-1:0] prescaler;
   logic [2:0]    word;
   logic          wr;
   logic          rd;
   logic          tick;
   logic [31:0]   rdata_mux;
   logic          unused_addr;

   assign word        = bus.bus_addr[4:2];
   assign wr          = bus.bus_req && bus.bus_we;
   assign rd          = bus.bus_req && !bus.bus_we;
   assign tick        = !dbg_halt && (prescaler == PW'(TICK_DIV - 1));
   assign unused_addr = ^bus.bus_addr[1:0];

   // The hi word returns the snapshot taken by the last lo read, so lo-then-hi is coherent.
   always_comb begin
      rdata_mux = '0;
      case (word)
         3'd0:    rdata_mux = {31'd0, msip};
         3'd2:    rdata_mux = mtimecmp[31:0];
         3'd3:    rdata_mux = mtimecmp[63:32];
         3'd4:    rdata_mux = mtime[31:0];
         3'd5:    rdata_mux = hi_shadow;
         default: rdata_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime         <= '0;
         mtimecmp      <= '1;
         msip          <= 1'b0;
         hi_shadow     <= '0;
         prescaler     <= '0;
         bus.bus_ack   <= 1'b0;
         bus.bus_rdata <= '0;
         xTIP          <= 1'b0;
         xSIP          <= 1'b0;
      end else begin
         bus.bus_ack   <= bus.bus_req;
         bus.bus_rdata <= rd ? rdata_mux : 32'd0;

         if (rd && word == 3'd4) hi_shadow <= mtime[63:32];
         if (wr && word == 3'd0) msip <= bus.bus_wdata[0];
         if (wr && word == 3'd2) mtimecmp[31:0]  <= bus.bus_wdata;
         if (wr && word == 3'd3) mtimecmp[63:32] <= bus.bus_wdata;

         // A software write to either mtime half suppresses that cycle's tick.
         if (wr && (word == 3'd4 || word == 3'd5)) begin
            if (word == 3'd4) mtime[31:0]  <= bus.bus_wdata;
            else              mtime[63:32] <= bus.bus_wdata;
            prescaler <= '0;
         end else if (tick) begin
            mtime     <= mtime + 64'd1;
            prescaler <= '0;
         end else if (!dbg_halt) begin
            prescaler <= prescaler + 1'b1;
         end

         xTIP <= (mtime >= mtimecmp);
         xSIP <= msip;
      end
   end
endmodule
